// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU): 34 edges from start to ready, 2 for divide-by-zero.
// No backpressure: result and ready hold while start_i stays high; annul_i aborts an in-flight divide.
module div_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES);

  state_t      state;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic [5:0]  cnt;
  logic        signed_div;
  logic        op1_sign;
  logic        op2_sign;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] diff;

  assign abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  // Bit 32 is the borrow: set when the partial remainder is smaller than the divisor.
  assign diff = {1'b0, dividend[63:32]} - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FREE;
      cnt        <= 6'd0;
      dividend   <= 65'd0;
      divisor    <= 32'd0;
      signed_div <= 1'b0;
      op1_sign   <= 1'b0;
      op2_sign   <= 1'b0;
      result_o   <= 64'd0;
      ready_o    <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= BYZERO;
            end else begin
              state      <= ON;
              cnt        <= 6'd0;
              dividend   <= {32'd0, abs1, 1'b0};
              divisor    <= abs2;
              signed_div <= signed_div_i;
              op1_sign   <= opdata1_i[31];
              op2_sign   <= opdata2_i[31];
            end
          end
        end

        BYZERO: begin
          dividend <= 65'd0;
          state    <= END;
        end

        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt != LAST_CNT) begin
            if (diff[32]) begin
              dividend <= {dividend[63:0], 1'b0};
            end else begin
              dividend <= {diff[31:0], dividend[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            // Quotient takes the XOR of the signs, remainder the dividend's sign.
            if (signed_div && (op1_sign != op2_sign)) begin
              dividend[31:0] <= ~dividend[31:0] + 32'd1;
            end
            if (signed_div && op1_sign) begin
              dividend[64:33] <= ~dividend[64:33] + 32'd1;
            end
            cnt   <= 6'd0;
            state <= END;
          end
        end

        END: begin
          if (start_i) begin
            result_o <= {dividend[64:33], dividend[31:0]};
            ready_o  <= 1'b1;
          end else begin
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotient/remainder vectors, latency, hold, abort and reset cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_unit #(.DIV_CYCLES(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives a request and consumes edge E0, then scrambles operands to show they were latched.
  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    signed_div_i = ~sgn;
    opdata1_i    = 32'h5A5A_5A5A;
    opdata2_i    = 32'h0000_0000;
  endtask

  // Called right after E0: checks ready timing at E33/E34, hold while start stays high, and release.
  task automatic finish_div(input string tag, input logic [63:0] exp);
    repeat (33) tick();
    chk({tag, "_early"}, 64'(ready_o), 64'd0);
    tick();
    chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_res"}, result_o, exp);
    repeat (3) tick();
    chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_res"}, result_o, exp);
    start_i = 1'b0;
    tick();
    chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  task automatic by_zero(input string tag, input logic sgn, input logic [31:0] a);
    start_div(sgn, a, 32'd0);
    tick();
    chk({tag, "_e1_rdy"}, 64'(ready_o), 64'd0);
    tick();
    chk({tag, "_e2_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_e2_res"}, result_o, 64'd0);
    start_i = 1'b0;
    tick();
    chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    int hi_cnt;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) tick();
    chk("reset_rdy", 64'(ready_o), 64'd0);
    chk("reset_res", result_o, 64'd0);
    rst = 1'b0;
    tick();

    start_div(1'b0, 32'd100, 32'd7);
    finish_div("divu_100_7", 64'h00000002_0000000E);

    start_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    finish_div("div_m7_2", 64'hFFFFFFFF_FFFFFFFD);

    start_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    finish_div("div_7_m2", 64'h00000001_FFFFFFFD);

    start_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    finish_div("div_m100_m7", 64'hFFFFFFFE_0000000E);

    start_div(1'b0, 32'hFFFF_FFF9, 32'd2);
    finish_div("divu_fff9_2", 64'h00000001_7FFFFFFC);

    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_div("div_ovf", 64'h00000000_80000000);

    by_zero("divu_zero", 1'b0, 32'd5);
    by_zero("div_zero", 1'b1, 32'hFFFF_FFFB);

    // Annul at E10 with start withdrawn: no ready for 40 cycles.
    start_div(1'b0, 32'd1000, 32'd3);
    repeat (9) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    chk("annul_e10_rdy", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    hi_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o !== 1'b0) hi_cnt++;
    end
    chk("annul_quiet", 64'(hi_cnt), 64'd0);
    start_div(1'b0, 32'hFFFF_FFFF, 32'h10);
    finish_div("divu_after_annul", 64'h0000000F_0FFFFFFF);

    // Annul at E10 with start held: the next edge begins a fresh divide from FREE.
    start_div(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    annul_i   = 1'b1;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_div_i = 1'b0;
    tick();
    chk("annul_held_rdy", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    tick();
    finish_div("divu_restart", 64'h00000001_0000014D);

    // Start together with annul in FREE is ignored.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    tick();
    chk("free_annul_rdy", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    start_div(1'b0, 32'd100, 32'd7);
    finish_div("after_free_annul", 64'h00000002_0000000E);

    // Reset at E20, start held: restart completes 34 edges after release.
    start_div(1'b0, 32'd100, 32'd7);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    rst = 1'b0;
    start_div(1'b0, 32'd100, 32'd7);
    finish_div("after_rst", 64'h00000002_0000000E);

    // Reset while a result is being held.
    start_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (34) tick();
    chk("end_rdy", 64'(ready_o), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_end_rdy", 64'(ready_o), 64'd0);
    chk("rst_end_res", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
